// File: rtl/qix_audio_out.sv
`default_nettype none
// ============================================================================
//  Module      : qix_audio_out
//  Description : Stereo DAC output stage for the Qix sound CPU. Latches the
//                8-bit DAC byte and the packed L/R volume byte, ramps each
//                channel's applied volume one step per ramp tick toward its
//                target (0 while paused), and emits signed 16-bit stereo
//                samples at a fixed rate through a 3-stage pipeline.
//  Ports       : clk_20m       - system clock
//                reset_n       - asynchronous active-low reset
//                dac_data/wr   - unsigned DAC byte (0x80 = silence) + strobe
//                vol_data/wr   - target volumes [3:0]=left [7:4]=right + strobe
//                pause         - while high both channels fade to 0
//                sound_l/r     - signed 16-bit output samples
//                sample_strobe - one-cycle pulse when sound_l/r update
//  Revision    : 1.0 - initial release
// ============================================================================
module qix_audio_out #(
    parameter int SAMPLE_DIV = 417,
    parameter int RAMP_DIV   = 20000
) (
    input  logic        clk_20m,
    input  logic        reset_n,
    input  logic [7:0]  dac_data,
    input  logic        dac_wr,
    input  logic [7:0]  vol_data,
    input  logic        vol_wr,
    input  logic        pause,
    output logic [15:0] sound_l,
    output logic [15:0] sound_r,
    output logic        sample_strobe
);

    localparam int c_SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_SW-1:0] c_SAMPLE_LAST = c_SW'(SAMPLE_DIV - 1);
    localparam logic [c_RW-1:0] c_RAMP_LAST   = c_RW'(RAMP_DIV - 1);

    logic [c_SW-1:0]    r_sample_cnt;
    logic [c_RW-1:0]    r_ramp_cnt;
    logic [7:0]         r_dac_q;
    logic [3:0]         r_tgt_l, r_tgt_r;
    logic [3:0]         r_cur_l, r_cur_r;

    // Pipeline: stage 1 (captured on sample tick), stage 2 (products)
    logic               r_v1, r_v2;
    logic [8:0]         r_s;
    logic [3:0]         r_cur1_l, r_cur1_r;
    logic signed [12:0] r_p_l, r_p_r;

    logic               w_sample_tick, w_ramp_tick;
    logic [3:0]         w_eff_l, w_eff_r;
    logic [3:0]         w_cur_l_nxt, w_cur_r_nxt;
    logic [8:0]         w_s;
    logic signed [12:0] w_prod_l, w_prod_r;

    assign w_sample_tick = (r_sample_cnt == c_SAMPLE_LAST);
    assign w_ramp_tick   = (r_ramp_cnt == c_RAMP_LAST);

    assign w_eff_l = pause ? 4'd0 : r_tgt_l;
    assign w_eff_r = pause ? 4'd0 : r_tgt_r;

    // One step toward the effective target; equality holds, so the ramp can
    // never overshoot and cur stays within 0..15.
    always_comb begin
        w_cur_l_nxt = r_cur_l;
        w_cur_r_nxt = r_cur_r;
        if (r_cur_l < w_eff_l)
            w_cur_l_nxt = r_cur_l + 4'd1;
        else if (r_cur_l > w_eff_l)
            w_cur_l_nxt = r_cur_l - 4'd1;
        if (r_cur_r < w_eff_r)
            w_cur_r_nxt = r_cur_r + 4'd1;
        else if (r_cur_r > w_eff_r)
            w_cur_r_nxt = r_cur_r - 4'd1;
    end

    // Offset-binary to two's complement: -128..+127 in 9 bits.
    assign w_s = {1'b0, r_dac_q} - 9'd128;

    // 9-bit signed sample times 4-bit unsigned volume, both widened to 13 bits.
    assign w_prod_l = $signed({{4{r_s[8]}}, r_s}) * $signed({9'd0, r_cur1_l});
    assign w_prod_r = $signed({{4{r_s[8]}}, r_s}) * $signed({9'd0, r_cur1_r});

    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_cnt <= '0;
            r_ramp_cnt   <= '0;
        end else begin
            r_sample_cnt <= w_sample_tick ? '0 : r_sample_cnt + 1'b1;
            r_ramp_cnt   <= w_ramp_tick ? '0 : r_ramp_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            r_dac_q <= 8'h80;
            r_tgt_l <= 4'hF;
            r_tgt_r <= 4'hF;
            r_cur_l <= 4'd0;
            r_cur_r <= 4'd0;
        end else begin
            if (dac_wr)
                r_dac_q <= dac_data;
            if (vol_wr) begin
                r_tgt_l <= vol_data[3:0];
                r_tgt_r <= vol_data[7:4];
            end
            // Steps toward the pre-write target when vol_wr shares the tick.
            if (w_ramp_tick) begin
                r_cur_l <= w_cur_l_nxt;
                r_cur_r <= w_cur_r_nxt;
            end
        end
    end

    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_s           <= '0;
            r_cur1_l      <= '0;
            r_cur1_r      <= '0;
            r_p_l         <= '0;
            r_p_r         <= '0;
            sound_l       <= '0;
            sound_r       <= '0;
            sample_strobe <= 1'b0;
        end else begin
            r_v1          <= w_sample_tick;
            r_v2          <= r_v1;
            sample_strobe <= r_v2;
            if (w_sample_tick) begin
                r_s      <= w_s;
                r_cur1_l <= r_cur_l;
                r_cur1_r <= r_cur_r;
            end
            if (r_v1) begin
                r_p_l <= w_prod_l;
                r_p_r <= w_prod_r;
            end
            // |p| <= 1920 fits in 12 bits, so dropping bit 12 is lossless.
            if (r_v2) begin
                sound_l <= {r_p_l[11:0], 4'b0000};
                sound_r <= {r_p_r[11:0], 4'b0000};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qix_audio_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qix_audio_out
//  Description : Self-checking bench for qix_audio_out: reset state, idle
//                strobe timing, a table of DAC/volume vectors, ramp-down,
//                pause fade, same-cycle DAC write and mid-pipeline reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qix_audio_out;

    localparam int SD = 417;
    localparam int RD = 450;

    logic        clk_20m = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  dac_data = 8'h00;
    logic        dac_wr = 1'b0;
    logic [7:0]  vol_data = 8'h00;
    logic        vol_wr = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] sound_l, sound_r;
    logic        sample_strobe;

    int checks = 0;
    int failures = 0;

    qix_audio_out #(.SAMPLE_DIV(SD), .RAMP_DIV(RD)) dut (
        .clk_20m       (clk_20m),
        .reset_n       (reset_n),
        .dac_data      (dac_data),
        .dac_wr        (dac_wr),
        .vol_data      (vol_data),
        .vol_wr        (vol_wr),
        .pause         (pause),
        .sound_l       (sound_l),
        .sound_r       (sound_r),
        .sample_strobe (sample_strobe)
    );

    always #5 clk_20m = ~clk_20m;

    typedef struct {
        logic [7:0] dac;
        logic [7:0] vol;
        bit         settle;
        int         exp_l;
        int         exp_r;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_20m);
    endtask

    // Returns number of negedges until the strobe is seen (0 on timeout).
    task automatic wait_strobe(output int n);
        n = 0;
        for (int i = 1; i <= SD + 10; i++) begin
            @(negedge clk_20m);
            if (sample_strobe) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL strobe_timeout got=none required=strobe within %0d cycles", SD + 10);
        end
    endtask

    task automatic write_regs(input logic [7:0] d, input logic [7:0] v);
        @(negedge clk_20m);
        dac_data = d;
        dac_wr   = 1'b1;
        vol_data = v;
        vol_wr   = 1'b1;
        @(negedge clk_20m);
        dac_wr   = 1'b0;
        vol_wr   = 1'b0;
    endtask

    task automatic write_dac(input logic [7:0] d);
        @(negedge clk_20m);
        dac_data = d;
        dac_wr   = 1'b1;
        @(negedge clk_20m);
        dac_wr   = 1'b0;
    endtask

    task automatic write_vol(input logic [7:0] v);
        @(negedge clk_20m);
        vol_data = v;
        vol_wr   = 1'b1;
        @(negedge clk_20m);
        vol_wr   = 1'b0;
    endtask

    function automatic int sl();
        return int'($signed(sound_l));
    endfunction

    function automatic int sr();
        return int'($signed(sound_r));
    endfunction

    initial begin
        int n;
        int prev, d, steps, bad, nstr, scount;
        bit done;

        vecs[0] = '{dac: 8'hFF, vol: 8'hF0, settle: 1'b1, exp_l: 0,      exp_r: 30480};
        vecs[1] = '{dac: 8'h00, vol: 8'hF0, settle: 1'b0, exp_l: 0,      exp_r: -30720};
        vecs[2] = '{dac: 8'h90, vol: 8'hF0, settle: 1'b0, exp_l: 0,      exp_r: 3840};
        vecs[3] = '{dac: 8'h7F, vol: 8'hF0, settle: 1'b0, exp_l: 0,      exp_r: -240};
        vecs[4] = '{dac: 8'hFF, vol: 8'h35, settle: 1'b1, exp_l: 10160,  exp_r: 6096};
        vecs[5] = '{dac: 8'h80, vol: 8'h35, settle: 1'b0, exp_l: 0,      exp_r: 0};
        vecs[6] = '{dac: 8'h01, vol: 8'h35, settle: 1'b0, exp_l: -10160, exp_r: -6096};
        vecs[7] = '{dac: 8'hFF, vol: 8'hFF, settle: 1'b1, exp_l: 30480,  exp_r: 30480};

        // Reset state
        wait_cycles(3);
        check("reset_sound_l", sl(), 0);
        check("reset_sound_r", sr(), 0);
        check("reset_strobe", int'(sample_strobe), 0);

        // Idle after release: silence, first strobe at SD+2, then every SD
        reset_n = 1'b1;
        wait_strobe(n);
        check("first_strobe_latency", n, SD + 2);
        check("idle_sound_l_0", sl(), 0);
        check("idle_sound_r_0", sr(), 0);
        wait_strobe(n);
        check("strobe_spacing", n, SD);
        check("idle_sound_l_1", sl(), 0);
        check("idle_sound_r_1", sr(), 0);

        // Table-driven DAC/volume vectors
        for (int i = 0; i < 8; i++) begin
            write_regs(vecs[i].dac, vecs[i].vol);
            if (vecs[i].settle)
                wait_cycles(16 * RD);
            wait_strobe(n);
            wait_strobe(n);
            check($sformatf("vec%0d_sound_l", i), sl(), vecs[i].exp_l);
            check($sformatf("vec%0d_sound_r", i), sr(), vecs[i].exp_r);
        end

        // Ramp down 15 -> 0 with DAC at 0xFF
        write_vol(8'h00);
        prev  = 30480;
        steps = 0;
        bad   = 0;
        nstr  = 0;
        done  = 1'b0;
        for (int k = 0; k < 25 && !done; k++) begin
            wait_strobe(n);
            if (n == 0)
                break;
            nstr++;
            d = prev - sl();
            if (d == 2032)
                steps++;
            else if (d != 0)
                bad++;
            prev = sl();
            if (sl() == 0)
                done = 1'b1;
        end
        check("desc_final_l", sl(), 0);
        check("desc_final_r", sr(), 0);
        check("desc_steps_2032", steps, 15);
        check("desc_bad_steps", bad, 0);
        check("desc_within_15_ticks", (nstr <= 19) ? 1 : 0, 1);

        // Pause fade and recovery; a DAC write during pause is still latched
        write_vol(8'hFF);
        wait_cycles(16 * RD);
        wait_strobe(n);
        wait_strobe(n);
        check("prepause_sound_l", sl(), 30480);
        check("prepause_sound_r", sr(), 30480);
        @(negedge clk_20m);
        pause = 1'b1;
        wait_cycles(5 * RD);
        write_dac(8'h00);
        wait_cycles(15 * RD);
        wait_strobe(n);
        wait_strobe(n);
        check("pause_sound_l", sl(), 0);
        check("pause_sound_r", sr(), 0);
        @(negedge clk_20m);
        pause = 1'b0;
        wait_cycles(16 * RD);
        wait_strobe(n);
        wait_strobe(n);
        check("unpause_sound_l", sl(), -30720);
        check("unpause_sound_r", sr(), -30720);

        // dac_wr in the exact cycle of a sample tick
        wait_strobe(n);
        wait_cycles(SD - 3);
        dac_data = 8'hFF;
        dac_wr   = 1'b1;
        @(negedge clk_20m);
        dac_wr   = 1'b0;
        wait_strobe(n);
        check("tickwr_latency", n, 2);
        check("tickwr_old_value", sl(), -30720);
        wait_strobe(n);
        check("tickwr_new_value", sl(), 30480);

        // Reset between a sample tick and its strobe
        wait_strobe(n);
        wait_cycles(SD - 2);
        reset_n = 1'b0;
        #1;
        check("midreset_sound_l", sl(), 0);
        check("midreset_sound_r", sr(), 0);
        wait_cycles(2);
        reset_n = 1'b1;
        scount = 0;
        for (int i = 0; i < SD; i++) begin
            @(negedge clk_20m);
            if (sample_strobe)
                scount++;
        end
        check("midreset_no_strobe", scount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qix_audio_out.md
# qix_audio_out

Stereo DAC output stage directly downstream of the Qix sound CPU. It latches the 8-bit DAC byte and the packed left/right volume byte written by the sound CPU's PIA ports, and ramps each channel's applied volume toward its target to avoid clicks. On a fixed output sample rate it produces the signed 16-bit stereo samples consumed by the core's audio output, and it fades both channels out while the core is paused.

## Interface
Parameters:
- SAMPLE_DIV, 417: clk_20m cycles per output sample (about 48 kHz).
- RAMP_DIV, 20000: clk_20m cycles per volume ramp step (1 kHz).

Ports:
- clk_20m  in  1  system clock. The block has one clock.
- reset_n  in  1  reset, asynchronous, active-low.
- dac_data  in  8  unsigned DAC byte from the sound CPU PIA; 0x80 is silence.
- dac_wr  in  1  one-cycle strobe that latches dac_data.
- vol_data  in  8  packed target volumes: [3:0] is left, [7:4] is right.
- vol_wr  in  1  one-cycle strobe that latches vol_data.
- pause  in  1  level input; while high, both channels fade to 0.
- sound_l  out  16  signed left sample.
- sound_r  out  16  signed right sample.
- sample_strobe  out  1  one-cycle pulse, asserted in the same cycle that sound_l and sound_r take a new value.

## Operation
- DAC latch: dac_q <= dac_data on dac_wr. The signed value is s = dac_q − 128, held as 9-bit signed in the range −128..+127.
- Volume latch: tgt_l <= vol_data[3:0] and tgt_r <= vol_data[7:4] on vol_wr.
- Effective target: eff_x = pause ? 0 : tgt_x.
- Ramp: on each ramp tick, cur_x moves 1 step toward eff_x (+1 if below, −1 if above, unchanged if equal). Each channel ramps independently. A full 15→0 fade takes 15 ticks (15 ms at default parameters).
- Sample tick counter: sample_cnt counts 0..SAMPLE_DIV−1. The tick fires in the cycle where the count equals SAMPLE_DIV−1, and the counter wraps to 0 in that cycle.
- Ramp tick counter: ramp_cnt works the same way against RAMP_DIV.
- Product:
  - p_x = s × cur_x, 13-bit signed, range −1920..+1905.
  - Output value = p_x << 4, giving range −30720..+30480. This always fits in 16 bits, so no clamping is needed.
- Pipeline:
  - Stage 1, registered on the sample tick: s and cur_l/cur_r are captured.
  - Stage 2: both products are registered.
  - Stage 3: sound_l and sound_r are registered, and sample_strobe pulses.
- Volume 0 gives an output of exactly 0 for any DAC value. A DAC value of 0x80 gives exactly 0 for any volume.

## Timing
- Reset values (asynchronous, while reset_n is low):
  - sound_l = sound_r = 0, sample_strobe = 0.
  - dac_q = 0x80.
  - tgt_l = tgt_r = 0xF.
  - cur_l = cur_r = 0.
  - sample_cnt = ramp_cnt = 0.
  - All pipeline registers = 0.
- After reset release: the first sample tick occurs at cycle SAMPLE_DIV−1, counting from 0 at the first active edge. sample_strobe follows 2 cycles later. The volume ramps up from 0 to 15 over 15 ramp ticks.
- Latency: a sample tick at cycle T produces sample_strobe and the new outputs at T+2. Outputs hold their value between strobes.
- dac_wr in the same cycle as a sample tick: the tick captures the old dac_q. The new value appears in the next sample.
- vol_wr in the same cycle as a ramp tick: the ramp steps toward the old target. The new target applies from the next tick.
- vol_wr mid-ramp: the target is replaced and the ramp continues from the current cur_x. There is no jump.
- pause asserted mid-ramp: the direction reverses at the next tick, heading to 0. On pause release, the ramp climbs back to tgt_x. DAC and volume writes are still latched during pause.
- Back-to-back dac_wr: the last write before the sample tick wins.
- Saturation: cur_x never leaves the range 0..15, and the ramp never overshoots its target.
- reset_n asserted mid-pipeline: all state clears immediately. A strobe that was in flight is dropped.

## Test plan
- Reset then idle (dac_q = 0x80): sound_l = sound_r = 0 on every strobe, and strobes are spaced exactly 417 cycles apart.
- dac_wr 0xFF, vol_wr 0xF0, wait 20 ramp ticks: sound_l = 0 and sound_r = 127×15×16 = 30480. Then dac_wr 0x00 gives sound_r = −30720.
- With the volume settled at 15/15, vol_wr 0x00: each ramp tick lowers cur_x by 1. With the DAC at 0xFF, successive strobes show sound_l falling from 30480 in steps of 2032 down to 0 within 15 ticks.
- pause high for 20 ramp ticks: both outputs reach 0. Pause low: both outputs return to their full values within 15 ticks, and tgt_x is unchanged.
- Assert dac_wr in the exact cycle of a sample tick: the following strobe still shows the old value, and the next strobe shows the new value.
- Pulse reset_n low between a sample tick and its strobe: no strobe is emitted, and outputs read 0 immediately.
